// File: rtl/pair_triple_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pair_triple_pkg
// Brief    : Shared debounce state encoding and seven-segment constants.
// Revision : 1.0
// ============================================================================
package pair_triple_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    code = SEG_BLANK;
    if (digit <= BCD_MAX) begin
      code = SEG_TABLE[digit];
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/detect_event_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : detect_event_counter_if
// Brief    : Control inputs and display outputs of the event counter.
// Revision : 1.0
// ============================================================================
interface detect_event_counter_if;
  logic       en;
  logic       det_in;
  logic       clr;
  logic [3:0] count;
  logic [6:0] seg;
  logic       dp;
  logic       event_pulse;

  modport master (
    output en, det_in, clr,
    input  count, seg, dp, event_pulse
  );

  modport slave (
    input  en, det_in, clr,
    output count, seg, dp, event_pulse
  );
endinterface
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Brief    : Synchroniser plus four-state debounce FSM; strobes on rising edges.
// Revision : 1.0
// ============================================================================
module sync_debounce
  import pair_triple_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic det_in,
  output logic rise_pulse,
  output logic rise_next
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // The transition into WAIT_* already consumed the first sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   rise_q, rise_d;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], det_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else if (en) begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_pulse = rise_q;
  // Lets the parent update the count on the same edge the strobe rises.
  assign rise_next  = rise_d;

endmodule
`default_nettype wire

// File: rtl/detect_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : detect_event_counter
// Brief    : Debounced rising-edge BCD counter driving a seven-segment digit.
// Revision : 1.0
// ============================================================================
module detect_event_counter
  import pair_triple_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  detect_event_counter_if.slave bus
);

  logic       rise_pulse;
  logic       rise_next;
  logic [3:0] count_q, count_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .det_in     (bus.det_in),
    .rise_pulse (rise_pulse),
    .rise_next  (rise_next)
  );

  always_comb begin
    count_d = count_q;
    dp_d    = dp_q;
    if (bus.clr) begin
      count_d = 4'd0;
      dp_d    = 1'b0;
    end else if (rise_next) begin
      if (count_q >= BCD_MAX) begin
        count_d = 4'd0;
        dp_d    = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
    // Decode the next value so seg and count move together.
    seg_d = seg_decode(count_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
      seg_q   <= SEG_TABLE[0];
      dp_q    <= 1'b0;
    end else if (bus.en) begin
      count_q <= count_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.event_pulse = rise_pulse;

endmodule
`default_nettype wire

// File: doc/detect_event_counter.md
# detect_event_counter

Downstream stage of the pair/triple detector on the TinyTapeout top level. Takes the detector's single-bit output (ultimately driven by the input switches, so asynchronous and bouncy), synchronises and debounces it, and counts rising edges of the filtered level as a BCD digit 0–9. The digit drives the seven-segment display on `uo_out`. The decimal point flags that the count has wrapped at least once.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count, ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a level change, ≥2.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset; top level drives it from `~rst_n`.
- `en` input 1: design enable (`ena`); low freezes all state.
- `det_in` input 1: raw detector output, asynchronous.
- `clr` input 1: synchronous clear of count and wrap flag.
- `count` output 4: current BCD digit, 0–9.
- `seg` output 7: active-high segments, `seg[0]`=a … `seg[6]`=g, decode of `count`.
- `dp` output 1: sticky wrap flag (decimal point).
- `event_pulse` output 1: one-cycle strobe per accepted rising edge.

## Operation
- Reset values: `count`=0, `seg`=7'b0111111 (digit 0), `dp`=0, `event_pulse`=0, synchroniser flops 0, FSM IDLE_LOW, debounce counter 0.
- Synchroniser: `SYNC_STAGES`-deep flop chain on `det_in`; its output is `s`.
- Debounce FSM, 4 states:
  - IDLE_LOW: `s`=1 → WAIT_HIGH with counter cleared.
  - WAIT_HIGH: `s`=0 → IDLE_LOW. On `s`=1, counter increments; on the `DEBOUNCE_CYCLES`-th consecutive high sample → IDLE_HIGH and assert `event_pulse`.
  - IDLE_HIGH: `s`=0 → WAIT_LOW with counter cleared.
  - WAIT_LOW: `s`=1 → IDLE_HIGH. On the `DEBOUNCE_CYCLES`-th consecutive low sample → IDLE_LOW. No event on falling edges.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`; saturates and never wraps.
- Counter: each `event_pulse` sets `count` ← `count`+1, except 9 → 0, which also sets `dp`=1.
- `dp` stays set until `clr` or `rst`.
- `clr`=1 (with `en`=1): `count`←0 and `dp`←0 on the next edge. `clr` has no effect on the synchroniser or the FSM.
- `clr` coincident with an accepted edge: clear wins (`count`=0, `dp`=0); `event_pulse` still asserts.
- `en`=0: every register holds, including the synchroniser and debounce counter. Edges occurring while disabled are seen only if the level persists after `en` returns.
- Reset mid-debounce: FSM returns to IDLE_LOW. If `det_in` is still high after reset releases, it is filtered and counted as a new rising edge.
- `seg` is a registered decode of the next `count`, so `seg` and `count` always change on the same edge. Codes 10–15 are unreachable; decode them to all-off.

## Timing
- `det_in` high and stable from before edge 0 with `en`=1: `event_pulse`=1 and `count` updated after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`−1, i.e. visible in cycle 18 with defaults.
- `event_pulse` width is exactly one cycle. Minimum spacing between pulses is 2·`DEBOUNCE_CYCLES` cycles, since a low phase must also be accepted.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event and no count change.
- `clr` latency is 1 cycle. `rst` acts immediately, asynchronously, and releases into the reset values.

## Structure
- Shared package `pair_triple_pkg`:
  - FSM state encoding (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW).
  - Seven-segment constant table for 0–9.
  - Blank code.
  - BCD maximum, 9.
- One sub-module: `sync_debounce` (synchroniser + FSM + debounce counter, output `rise_pulse`). The parent holds the BCD counter, `dp` and the `seg` register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2.
1. Reset: assert `rst` mid-cycle → outputs immediately `count`=0, `seg`=0x3F, `dp`=0, `event_pulse`=0.
2. Clean press: `det_in` 0→1, held 20 cycles → single `event_pulse` exactly 5 cycles after the first sampling edge; `count`=1, `seg`=0x06.
3. Bounce: `det_in` toggles 1,0,1,0 at 1-cycle intervals, then stays high → exactly one event, `count`=1; a 3-cycle high glitch alone → `count` unchanged.
4. Wrap: 10 clean presses → `count` sequence 1…9,0; `dp`=1 after the tenth press. `clr` → `count`=0, `dp`=0 next cycle.
5. Collisions: `clr` on the event cycle → `count`=0, `event_pulse`=1. `en`=0 across a full press → no event; `en` re-raised with `det_in` still high → event after 5 cycles.
6. Reset mid-WAIT_HIGH with `det_in` held high → no event before reset. After release, one event 5 cycles later; `count`=1.
